crc8_frame_sequencer: RTL and testbench

CRC8_FRAME_SEQUENCER -- requirements
Module: crc8_frame_sequencer

---
 rtl/crc8_frame_sequencer_if.sv | 26 ++
 rtl/crc8_frame_sequencer.sv | 112 +++++++++++
 tb/tb_crc8_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc8_frame_sequencer_if.sv
// Stream, lookup-table and result signals of the CRC-8 frame sequencer.
// master: the side that feeds bytes and supplies the table;
// slave: the sequencer itself.
interface crc8_frame_sequencer_if;
    logic       startFrame;
    logic       modeCheck;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;
    logic [7:0] tableIndex;
    logic [7:0] tableResult;
    logic [7:0] crcOut;
    logic       crcValid;
    logic       crcOk;
    logic       busy;

    modport master (
        output startFrame, modeCheck, dataIn, dataValid, tableResult,
        input  dataReady, tableIndex, crcOut, crcValid, crcOk, busy
    );

    modport slave (
        input  startFrame, modeCheck, dataIn, dataValid, tableResult,
        output dataReady, tableIndex, crcOut, crcValid, crcOk, busy
    );
endinterface

// File: rtl/crc8_frame_sequencer.sv
// CRC-8 (poly 0x07) frame sequencer.
// The block accumulates FRAME_LEN payload bytes, plus one trailing CRC byte in
// check mode, through an external byte lookup table. It then reports the final
// CRC register value with a one-cycle crcValid pulse.
//
// state  | meaning
// IDLE   | waiting for startFrame; stream input ignored
// ACCUM  | accepting bytes, dataReady high
// DONE   | one-cycle result strobe, then back to IDLE
module crc8_frame_sequencer #(
    parameter int         FRAME_LEN = 4,
    parameter logic [7:0] CRC_INIT  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    crc8_frame_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    // Nine-bit count so that FRAME_LEN=255 in check mode (256 bytes) cannot wrap.
    localparam logic [8:0] TARGET_GEN = 9'(FRAME_LEN);
    localparam logic [8:0] TARGET_CHK = 9'(FRAME_LEN + 1);

    state_t     state_q;
    logic [7:0] crc_q;
    logic [8:0] cnt_q;
    logic       mode_q;
    logic       ready_q;
    logic       valid_q;
    logic       busy_q;
    logic [7:0] crc_out_q;
    logic       ok_q;

    logic [8:0] cnt_d;
    logic [8:0] target;
    logic       accept;
    logic       last_byte;

    // Byte acceptance and end-of-frame detection for the current ACCUM cycle.
    always_comb begin
        target    = mode_q ? TARGET_CHK : TARGET_GEN;
        cnt_d     = cnt_q + 9'd1;
        accept    = bus.dataValid & ready_q;
        last_byte = accept && (cnt_d == target);
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            crc_q     <= CRC_INIT;
            cnt_q     <= 9'd0;
            mode_q    <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            crc_out_q <= 8'h00;
            ok_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.startFrame) begin
                        state_q <= S_ACCUM;
                        crc_q   <= CRC_INIT;
                        cnt_q   <= 9'd0;
                        mode_q  <= bus.modeCheck;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        crc_q <= bus.tableResult;
                        cnt_q <= cnt_d;
                    end
                    // The result registers take the final table output directly,
                    // so crcOut equals the CRC register throughout DONE.
                    if (last_byte) begin
                        state_q   <= S_DONE;
                        ready_q   <= 1'b0;
                        valid_q   <= 1'b1;
                        crc_out_q <= bus.tableResult;
                        ok_q      <= mode_q & (bus.tableResult == 8'h00);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tableIndex = crc_q ^ bus.dataIn;
    assign bus.dataReady  = ready_q;
    assign bus.crcValid   = valid_q;
    assign bus.crcOut     = crc_out_q;
    assign bus.crcOk      = ok_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_crc8_frame_sequencer.sv
// Bench for crc8_frame_sequencer.
// Three instances (FRAME_LEN 9, 1, 4) share one stimulus. Each instance has its
// own lookup table, and only the instance selected for a frame is checked.
module tb_crc8_frame_sequencer;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int         sel;
        bit         mode;
        int         n;
        logic [7:0] b [10];
        int         gap;
        logic [7:0] exp_crc;
        bit         exp_ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startFrame = 1'b0;
    logic       modeCheck = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       dataValid = 1'b0;

    logic [2:0] ready_a, valid_a, ok_a, busy_a;
    logic [7:0] crcOut_a [3];
    logic [7:0] index_a  [3];
    int         vcnt [3];
    int         fl [3] = '{9, 1, 4};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Byte-wise CRC-8 (poly 0x07) lookup table, as the shared ROM would hold it.
    function automatic logic [7:0] crc8_tab(input logic [7:0] idx);
        logic [7:0] c;
        c = idx;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Reference CRC: MSB-first polynomial division over the whole message, seed 0.
    function automatic logic [7:0] crc_model(input bq_t msg);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (msg[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ msg[i][k];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        localparam int FL = (g == 0) ? 9 : (g == 1) ? 1 : 4;
        crc8_frame_sequencer_if bus();
        assign bus.startFrame  = startFrame;
        assign bus.modeCheck   = modeCheck;
        assign bus.dataIn      = dataIn;
        assign bus.dataValid   = dataValid;
        assign bus.tableResult = crc8_tab(bus.tableIndex);
        crc8_frame_sequencer #(.FRAME_LEN(FL), .CRC_INIT(8'h00)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign ready_a[g]  = bus.dataReady;
        assign valid_a[g]  = bus.crcValid;
        assign ok_a[g]     = bus.crcOk;
        assign busy_a[g]   = bus.busy;
        assign crcOut_a[g] = bus.crcOut;
        assign index_a[g]  = bus.tableIndex;
    end

    // crcValid pulse counter per instance, sampled on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (valid_a[i]) vcnt[i] = vcnt[i] + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        startFrame = 1'b0;
        dataValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame on instance sel, starting at a negedge in IDLE and
    // returning at the negedge of the post-DONE IDLE cycle.
    // gap >= 0 is a fixed gap before each byte; gap < 0 gives random gaps of 0..3.
    // noise holds dataValid high in IDLE and DONE and pulses startFrame in ACCUM.
    task automatic run_frame(input int sel, input bit mode, input bq_t msg, input int gap,
                             input bit noise, input logic [7:0] exp_crc, input bit exp_ok,
                             input string tag);
        int v0;
        int ng;
        if (noise) begin
            dataValid = 1'b1;
            dataIn = 8'($urandom);
            @(negedge clk);
            chk({tag, " idle_data_ignored"}, 32'(busy_a[sel]), 0);
        end
        v0 = vcnt[sel];
        startFrame = 1'b1;
        modeCheck = mode;
        dataValid = 1'b0;
        @(negedge clk);
        startFrame = 1'b0;
        modeCheck = ~mode;
        chk({tag, " busy_in_accum"}, 32'(busy_a[sel]), 1);
        foreach (msg[i]) begin
            ng = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            repeat (ng) begin
                dataValid = 1'b0;
                startFrame = noise;
                @(negedge clk);
                startFrame = 1'b0;
                chk({tag, " ready_in_gap"}, 32'(ready_a[sel]), 1);
            end
            chk({tag, " ready_before_byte"}, 32'(ready_a[sel]), 1);
            dataValid = 1'b1;
            dataIn = msg[i];
            startFrame = noise;
            @(negedge clk);
            startFrame = 1'b0;
        end
        dataValid = noise;
        dataIn = 8'($urandom);
        chk({tag, " crcValid_latency"}, 32'(valid_a[sel]), 1);
        chk({tag, " crcOut"}, 32'(crcOut_a[sel]), 32'(exp_crc));
        chk({tag, " crcOk"}, 32'(ok_a[sel]), 32'(exp_ok));
        chk({tag, " ready_in_done"}, 32'(ready_a[sel]), 0);
        @(negedge clk);
        dataValid = 1'b0;
        chk({tag, " crcValid_one_cycle"}, 32'(valid_a[sel]), 0);
        chk({tag, " busy_after_done"}, 32'(busy_a[sel]), 0);
        chk({tag, " crcOut_held"}, 32'(crcOut_a[sel]), 32'(exp_crc));
        chk({tag, " pulses_per_frame"}, 32'(vcnt[sel] - v0), 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [6];
        bq_t  msg;
        bit   mode;
        int   v0;
        logic [7:0] e;

        for (int i = 0; i < 3; i++) vcnt[i] = 0;

        // Directed vectors: the known-answer frames.
        vt[0] = '{sel: 0, mode: 0, n: 9, b: '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h00},
                  gap: 0, exp_crc: 8'hF4, exp_ok: 0};
        vt[1] = '{sel: 0, mode: 1, n: 10, b: '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'hF4},
                  gap: 0, exp_crc: 8'h00, exp_ok: 1};
        vt[2] = '{sel: 0, mode: 1, n: 10, b: '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'hF5},
                  gap: 1, exp_crc: 8'h07, exp_ok: 0};
        vt[3] = '{sel: 1, mode: 0, n: 1, b: '{8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  gap: 3, exp_crc: 8'h07, exp_ok: 0};
        vt[4] = '{sel: 2, mode: 0, n: 4, b: '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  gap: 0, exp_crc: 8'h00, exp_ok: 0};
        vt[5] = '{sel: 2, mode: 1, n: 5, b: '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  gap: 2, exp_crc: 8'h00, exp_ok: 1};

        // Reset state, observed while rst is held.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy[%0d]", i), 32'(busy_a[i]), 0);
            chk($sformatf("reset_ready[%0d]", i), 32'(ready_a[i]), 0);
            chk($sformatf("reset_valid[%0d]", i), 32'(valid_a[i]), 0);
            chk($sformatf("reset_ok[%0d]", i), 32'(ok_a[i]), 0);
            chk($sformatf("reset_crcOut[%0d]", i), 32'(crcOut_a[i]), 0);
            chk($sformatf("reset_index[%0d]", i), 32'(index_a[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vt[i].sel != vt[i-1].sel) do_reset();
            msg = {};
            for (int j = 0; j < vt[i].n; j++) msg.push_back(vt[i].b[j]);
            run_frame(vt[i].sel, vt[i].mode, msg, vt[i].gap, 1'b0,
                      vt[i].exp_crc, vt[i].exp_ok, $sformatf("vec%0d", i));
        end

        // Ignored startFrame in ACCUM and dataValid in IDLE/DONE.
        do_reset();
        msg = {8'hA5, 8'h3C, 8'hFF, 8'h10};
        e = crc_model(msg);
        run_frame(2, 1'b0, msg, 1, 1'b1, e, 1'b0, "noise");
        msg = {8'h01, 8'h02, 8'h03, 8'h04};
        e = crc_model(msg);
        run_frame(2, 1'b0, msg, 0, 1'b1, e, 1'b0, "noise2");

        // Reset after 2 of 4 bytes aborts without a result pulse.
        do_reset();
        startFrame = 1'b1;
        modeCheck = 1'b0;
        @(negedge clk);
        startFrame = 1'b0;
        dataValid = 1'b1;
        dataIn = 8'h5A;
        @(negedge clk);
        dataIn = 8'hC3;
        @(negedge clk);
        dataValid = 1'b0;
        v0 = vcnt[2];
        rst = 1'b1;
        #1;
        chk("abort_busy_in_reset", 32'(busy_a[2]), 0);
        chk("abort_ready_in_reset", 32'(ready_a[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_after", 32'(busy_a[2]), 0);
        chk("abort_no_pulse", 32'(vcnt[2] - v0), 0);
        msg = {8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(2, 1'b0, msg, 0, 1'b0, 8'h00, 1'b0, "after_abort");

        // Random frames against the reference model, back-to-back per instance.
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int f = 0; f < 12; f++) begin
                mode = 1'($urandom);
                msg = {};
                for (int j = 0; j < fl[s]; j++) msg.push_back(8'($urandom));
                if (mode) msg.push_back(($urandom_range(0, 1) == 1) ? crc_model(msg) : 8'($urandom));
                e = crc_model(msg);
                run_frame(s, mode, msg, -1, 1'($urandom_range(0, 3) == 0), e,
                          mode && (e == 8'h00), $sformatf("rnd%0d_%0d", s, f));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
